// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, the NOP word and the fetch FSM state type.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JR    = 6'b100000;
  localparam logic [5:0] OP_J     = 6'b110000;
  localparam logic [5:0] OP_JAL   = 6'b111000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {inst, pc} holding slot for a word that arrives while ID is stalled.
module fetch_skid_buf
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              unload_i,
  input  logic              flush_i,
  input  logic [31:0]       inst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              valid_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic              valid_q, valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  // Flush wins so a redirect can never leak a wrong-path word.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      inst_d  = inst_i;
      pc_d    = pc_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_WORD;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake, IF/ID register, redirects and stall skid.
// state | meaning
// BOOT  | one idle cycle after reset, no request
// FETCH | request at pc; accept returned words
// HOLD  | word parked in skid while ID stalls, no request
// DRAIN | wrong-path request outstanding; discard its ack
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              jump_reg,
  input  logic [ADDR_W-1:0] jump_reg_target,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [5:0]        if_opcode,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4
);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [ADDR_W-1:0] if_pc4_q, if_pc4_d;

  logic              redirect;
  logic [ADDR_W-1:0] redir_tgt;
  logic              out_free;

  logic              skid_load, skid_unload, skid_flush;
  logic              skid_valid;
  logic [31:0]       skid_inst;
  logic [ADDR_W-1:0] skid_pc;

  always_comb begin
    redirect = jump_reg | jump | branch_taken;
    if (jump_reg) begin
      redir_tgt = jump_reg_target;
    end else if (jump) begin
      redir_tgt = jump_target;
    end else begin
      redir_tgt = branch_target;
    end
  end

  // An empty output register accepts a new word even under stall.
  assign out_free = ~if_valid_q | ~stall;

  fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .flush_i  (skid_flush),
    .inst_i   (imem_rdata),
    .pc_i     (pc_q),
    .valid_o  (skid_valid),
    .inst_o   (skid_inst),
    .pc_o     (skid_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    if_valid_d   = if_valid_q & stall;
    if_inst_d    = if_inst_q;
    if_pc_d      = if_pc_q;
    if_pc4_d     = if_pc4_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_flush   = 1'b0;
    imem_req     = 1'b0;
    imem_addr    = pc_q;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          drain_addr_d = pc_q;
          state_d      = imem_ack ? ST_FETCH : ST_DRAIN;
        end else if (imem_ack) begin
          pc_d = pc_q + STEP;
          if (out_free) begin
            if_valid_d = 1'b1;
            if_inst_d  = imem_rdata;
            if_pc_d    = pc_q;
            if_pc4_d   = pc_q + STEP;
          end else begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!redirect && !stall) begin
          skid_unload = 1'b1;
          if_valid_d  = skid_valid;
          if_inst_d   = skid_inst;
          if_pc_d     = skid_pc;
          if_pc4_d    = skid_pc + STEP;
          state_d     = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // Old address stays on the bus until memory answers the abandoned request.
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
        if (imem_ack) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (redirect) begin
      pc_d       = redir_tgt & ALIGN_MASK;
      if_valid_d = 1'b0;
      skid_flush = 1'b1;
      if (state_q == ST_HOLD) begin
        state_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      if_valid_q   <= 1'b0;
      if_inst_q    <= NOP_WORD;
      if_pc_q      <= '0;
      if_pc4_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      if_valid_q   <= if_valid_d;
      if_inst_q    <= if_inst_d;
      if_pc_q      <= if_pc_d;
      if_pc4_q     <= if_pc4_d;
    end
  end

  assign if_valid    = if_valid_q;
  assign if_inst     = if_inst_q;
  assign if_opcode   = if_inst_q[31:26];
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios plus a random run scored against an
// in-order instruction-stream model (each delivered word must be the next address of the current path).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jump_reg;
  logic [31:0] jump_reg_target;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [5:0]  if_opcode;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int n_checks = 0;
  int n_pass   = 0;
  int fixed_wait = 0;
  int mem_cnt    = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jump            (jump),
    .jump_target     (jump_target),
    .jump_reg        (jump_reg),
    .jump_reg_target (jump_reg_target),
    .if_valid        (if_valid),
    .if_inst         (if_inst),
    .if_opcode       (if_opcode),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA000_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
  endtask

  // Memory answers at the negedge; req/addr depend only on DUT registers so they are settled.
  task automatic mem_respond();
    if (imem_req) begin
      if (mem_cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        mem_cnt    = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        mem_cnt--;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
  endtask

  task automatic step();
    @(negedge clk);
    mem_respond();
  endtask

  task automatic clear_inputs();
    stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0;
    jump_reg = 1'b0; jump_reg_target = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    imem_ack = 1'b0;
    imem_rdata = '0;
    fixed_wait = 0;
    repeat (2) @(negedge clk);
    mem_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] a, input int budget);
    int n = 0;
    step();
    while (!(imem_req && imem_ack && imem_addr == a) && n < budget) begin
      step();
      n++;
    end
    check("wait_req_timeout", 32'(imem_req && imem_ack && imem_addr == a), 32'd1);
  endtask

  function automatic logic [31:0] pick_target();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return $urandom;
  endfunction

  initial begin
    logic [31:0] exp_pc;
    logic        prev_hold, prev_wait;
    logic [31:0] prev_pc, prev_inst, prev_addr;
    int          delivered;

    // Reset values and first-fetch latency
    rst = 1'b1;
    clear_inputs();
    imem_ack = 1'b0;
    imem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_pc4", if_pc_plus4, 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    mem_cnt = 0;
    rst = 1'b0;
    step();
    check("e1_if_valid", 32'(if_valid), 32'd0);
    check("e1_req", 32'(imem_req), 32'd1);
    check("e1_addr", imem_addr, 32'h0);
    step();
    check("e2_if_valid", 32'(if_valid), 32'd1);
    check("e2_if_pc", if_pc, 32'h0);
    check("e2_opcode", 32'(if_opcode), 32'(6'b101000));
    check("e2_pc4", if_pc_plus4, 32'h4);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("stream_valid", 32'(if_valid), 32'd1);
      check("stream_pc", if_pc, 32'(4 * k));
    end

    // Stall for three cycles while 0x10 is acked
    stall = 1'b1;
    repeat (3) begin
      step();
      check("stall_pc_hold", if_pc, 32'hC);
      check("stall_valid", 32'(if_valid), 32'd1);
      check("hold_no_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    step();
    check("unskid_pc", if_pc, 32'h10);
    check("unskid_inst", if_inst, mem_word(32'h10));
    step();
    check("after_skid_pc", if_pc, 32'h14);

    // Jump with an ack in the same cycle
    do_reset();
    wait_req(32'h10, 20);
    jump = 1'b1; jump_target = 32'h103;
    step();
    jump = 1'b0;
    check("jmp_valid_clr", 32'(if_valid), 32'd0);
    check("jmp_req", 32'(imem_req), 32'd1);
    check("jmp_addr", imem_addr, 32'h100);
    step();
    check("jmp_tgt_pc", if_pc, 32'h100);
    check("jmp_tgt_inst", if_inst, mem_word(32'h100));

    // Branch during a memory wait: drain the stale request
    do_reset();
    wait_req(32'hC, 20);
    fixed_wait = 2;
    step();
    step();
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    check("drain1_req", 32'(imem_req), 32'd1);
    check("drain1_addr", imem_addr, 32'h14);
    check("drain1_valid", 32'(if_valid), 32'd0);
    fixed_wait = 0;
    step();
    check("drain2_addr", imem_addr, 32'h14);
    check("drain2_valid", 32'(if_valid), 32'd0);
    step();
    check("post_drain_addr", imem_addr, 32'h40);
    check("post_drain_valid", 32'(if_valid), 32'd0);
    step();
    check("br_tgt_valid", 32'(if_valid), 32'd1);
    check("br_tgt_pc", if_pc, 32'h40);

    // Redirect priority, overriding stall
    do_reset();
    wait_req(32'h8, 20);
    stall = 1'b1;
    jump_reg = 1'b1; jump_reg_target = 32'h200;
    jump = 1'b1; jump_target = 32'h300;
    branch_taken = 1'b1; branch_target = 32'h400;
    step();
    jump_reg = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    check("prio_valid_clr", 32'(if_valid), 32'd0);
    check("prio_addr", imem_addr, 32'h200);
    step();
    check("prio_load_under_stall", 32'(if_valid), 32'd1);
    check("prio_pc", if_pc, 32'h200);
    stall = 1'b0;

    // Asynchronous reset in DRAIN
    do_reset();
    wait_req(32'h8, 20);
    fixed_wait = 1;
    step();
    step();
    jump = 1'b1; jump_target = 32'h80;
    step();
    jump = 1'b0;
    check("mid_drain_addr", imem_addr, 32'h10);
    #2 rst = 1'b1;
    #1;
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_valid", 32'(if_valid), 32'd0);
    check("arst_pc", if_pc, 32'd0);
    check("arst_inst", if_inst, 32'd0);
    imem_ack = 1'b0;
    fixed_wait = 0;
    @(negedge clk);
    mem_cnt = 0;
    rst = 1'b0;
    step();
    check("restart_addr", imem_addr, 32'h0);
    step();
    check("restart_pc", if_pc, 32'h0);

    // PC wrap
    do_reset();
    wait_req(32'h4, 20);
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", if_pc_plus4, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);
    step();
    check("wrap_next_pc", if_pc, 32'h0);

    // Random traffic against the in-order stream model
    do_reset();
    fixed_wait = -1;
    exp_pc = 32'h0;
    prev_hold = 1'b0; prev_wait = 1'b0;
    prev_pc = '0; prev_inst = '0; prev_addr = '0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (prev_hold) begin
        check("rnd_hold_valid", 32'(if_valid), 32'd1);
        check("rnd_hold_pc", if_pc, prev_pc);
        check("rnd_hold_inst", if_inst, prev_inst);
      end
      if (prev_wait) begin
        check("rnd_req_held", 32'(imem_req), 32'd1);
        check("rnd_addr_stable", imem_addr, prev_addr);
      end
      stall = ($urandom_range(0, 99) < 30);
      jump_reg = ($urandom_range(0, 99) < 2);
      jump = ($urandom_range(0, 99) < 2);
      branch_taken = ($urandom_range(0, 99) < 3);
      jump_reg_target = pick_target();
      jump_target = pick_target();
      branch_target = pick_target();
      if (jump_reg)          exp_pc = jump_reg_target & ~32'h3;
      else if (jump)         exp_pc = jump_target & ~32'h3;
      else if (branch_taken) exp_pc = branch_target & ~32'h3;
      else if (if_valid && !stall) begin
        check("rnd_pc", if_pc, exp_pc);
        check("rnd_inst", if_inst, mem_word(exp_pc));
        check("rnd_opcode", 32'(if_opcode), 32'(mem_word(exp_pc) >> 26));
        check("rnd_pc4", if_pc_plus4, exp_pc + 32'h4);
        exp_pc = exp_pc + 32'h4;
        delivered++;
      end
      prev_hold = if_valid && stall && !(jump_reg || jump || branch_taken);
      prev_pc   = if_pc;
      prev_inst = if_inst;
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
    clear_inputs();
    check("rnd_progress", 32'(delivered >= 200), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main control decoder.
- Holds the PC and issues requests to instruction memory over a req/ack handshake.
- Registers the fetched word into the IF/ID output register; if_opcode (if_inst[31:26]) drives the decoder's opcode input.
- Applies PC redirects from jump, jump-register and taken-branch resolution, flushes wrong-path instructions, and honours a downstream stall through a one-entry skid buffer.

Parameters:
ADDR_W, 32, PC/memory address width
RESET_PC, 0, PC value loaded on reset (word aligned)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address; stable while imem_req=1 until ack
imem_ack  in  1  memory returns data this cycle; may arrive in the same cycle as req
imem_rdata  in  32  instruction word, valid when imem_ack=1
stall  in  1  ID stage cannot accept; hold the output register
branch_taken  in  1  taken branch (beq) redirect
branch_target  in  ADDR_W  branch target
jump  in  1  j/jal redirect
jump_target  in  ADDR_W  j/jal target
jump_reg  in  1  jr redirect
jump_reg_target  in  ADDR_W  register value for jr
if_valid  out  1  output register holds a valid instruction
if_inst  out  32  fetched instruction
if_opcode  out  6  if_inst[31:26], to the control decoder
if_pc  out  ADDR_W  address of if_inst
if_pc_plus4  out  ADDR_W  if_pc+4, used for jal link and branch base

Behaviour:
- Reset (async, while rst=1):
  - pc=RESET_PC, state=BOOT, imem_req=0.
  - if_valid=0, if_inst=0 (NOP), if_pc=0, if_pc_plus4=0, skid empty, drop flag clear.
  - An outstanding memory request is abandoned.
- FSM states: BOOT, FETCH, HOLD, DRAIN.
- BOOT: one cycle, imem_req=0, then go to FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack:
  - If the output register is free (if_valid=0 or stall=0): load if_inst/if_pc/if_pc_plus4, set if_valid=1, pc<=pc+4, stay in FETCH.
  - Otherwise: capture {rdata, pc} into the skid buffer, pc<=pc+4, go to HOLD.
- Consumption: when stall=0 and no new data arrives, clear if_valid on the next edge.
- HOLD: imem_req=0. When stall=0, move the skid buffer into the output register (if_valid=1), empty the skid, and go to FETCH.
- Redirect (jump_reg, jump or branch_taken high):
  - Priority is jump_reg > jump > branch_taken.
  - Target bits [1:0] are forced to 0.
  - Next edge: pc<=target, if_valid<=0, skid emptied. Redirect overrides stall.
  - In FETCH with imem_ack in the same cycle: the returned word is discarded and the next state is FETCH at the target.
  - In FETCH without ack: the next state is DRAIN.
  - In HOLD: the next state is FETCH.
- DRAIN: imem_req=1 with the old address held stable. The next ack is discarded, then go to FETCH at the new pc. A further redirect while in DRAIN only updates pc.
- Throughput and latency:
  - With zero-wait memory: one instruction per cycle.
  - The first if_valid=1 appears at the 2nd rising edge after rst falls.
  - Each memory wait cycle adds exactly one cycle.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W; no overflow flag.
- stall with if_valid=0: the output register counts as free, so it loads.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants: OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_ADDI 6'b001000, OP_ANDI 6'b001100, OP_ORI 6'b001101, OP_BEQ 6'b000100, OP_JR 6'b100000, OP_J 6'b110000, OP_JAL 6'b111000.
  - NOP word 32'h0.
  - The fetch state enum.
- Sub-module fetch_skid_buf: a one-entry {inst, pc} buffer with load/unload/flush, instantiated once.

Test Plan:
- Reset release, RESET_PC=0, memory acks every cycle returning addr|0xA0000000 -> if_valid rises at edge 2 with if_pc=0, then 4, 8, 12 on consecutive cycles; if_opcode=6'b101000.
- stall held 3 cycles while pc=8 is acked -> fetch of 8 goes to skid, imem_req=0 in HOLD, if_pc stays at 4; stall drops -> if_pc=8 next edge, then 12; no word lost or duplicated.
- jump=1, jump_target=0x103 in the same cycle as an ack for 0x10 -> word for 0x10 dropped, if_valid=0 next edge, then the next request is imem_addr=0x100.
- Memory with 2 wait cycles; branch_taken=1 (target 0x40) in the first wait cycle -> imem_addr stays 0x14 until ack (DRAIN), that data is discarded, next request is 0x40, and no instruction from 0x14 reaches if_valid.
- jump_reg=1 (target 0x200), jump=1 (0x300) and branch_taken=1 (0x400) simultaneously, with stall=1 -> if_valid cleared despite stall, next fetch is 0x200.
- rst asserted mid-DRAIN -> outputs clear immediately (asynchronously); after release, fetch restarts at RESET_PC. With pc=0xFFFFFFFC: next pc=0x00000000.
